// File: rtl/encoder_counter.sv
// Quadrature encoder front end: 2-flop sync, prescaled debounce, x1 decode on
// rising A, and a wrapping or saturating value register.
module enc_debounce #(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic sig_i,
  output logic db_o
);
  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick_i) begin
      if (sig_i == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DB_COUNT - 1)) begin
        db_d  = sig_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;
endmodule

module encoder_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int DB_COUNT = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             a_db,
  output logic             b_db,
  output logic             step,
  output logic             dir
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Line 0 = A, line 1 = B
  logic [1:0] raw, s1_q, s2_q, db;
  assign raw = {enc_b, enc_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = ena && (pre_q == PW'(PRESCALE - 1));
  always_comb begin
    pre_d = pre_q;
    if (ena) pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    enc_debounce #(.DB_COUNT(DB_COUNT)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .sig_i  (s2_q[g]),
      .db_o   (db[g])
    );
  end

  assign a_db = db[0];
  assign b_db = db[1];

  logic             a_q, a_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             rise;

  assign rise = a_db & ~a_q;

  always_comb begin
    a_d     = a_q;
    value_d = value_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    if (ena) begin
      a_d = a_db;
      // Load wins over a coincident rise; that count is dropped.
      if (load) begin
        value_d = load_val;
      end else if (rise) begin
        step_d = 1'b1;
        dir_d  = ~b_db;
        if (!b_db) begin
          if (!(SATURATE && value_q == '1)) value_d = value_q + 1'b1;
        end else begin
          if (!(SATURATE && value_q == '0)) value_d = value_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 1'b0;
      value_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      value_q <= value_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
endmodule

// File: tb/tb_encoder_counter.sv
// Directed bench: default, saturating and prescaled instances share stimulus.
module tb_encoder_counter;
  logic       clk = 1'b0;
  logic       rst_n, ena, enc_a, enc_b, load;
  logic [7:0] load_val;

  logic [7:0] v0, v1, v2;
  logic       a0, a1, a2, b0, b1, b2, s0, s1, s2, d0, d1, d2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  encoder_counter u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_val(load_val), .value(v0), .a_db(a0), .b_db(b0),
    .step(s0), .dir(d0));

  encoder_counter #(.SATURATE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_val(load_val), .value(v1), .a_db(a1), .b_db(b1),
    .step(s1), .dir(d1));

  encoder_counter #(.PRESCALE(3), .DB_COUNT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b),
    .load(load), .load_val(load_val), .value(v2), .a_db(a2), .b_db(b2),
    .step(s2), .dir(d2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic detent(input logic b);
    enc_b = b;
    cyc(8);
    enc_a = 1'b1;
    cyc(10);
    enc_a = 1'b0;
    cyc(8);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    logic found;
    rst_n = 1'b0; ena = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
    load = 1'b0; load_val = '0;
    #2;
    chk("rst_value", v0, 0);
    chk("rst_lines", {a0, b0}, 0);
    chk("rst_stepdir", {s0, d0}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    // Clockwise first detent, edge-accurate
    enc_a = 1'b1;
    cyc(5);
    chk("cw_adb_e5", a0, 0);
    cyc(1);
    chk("cw_adb_e6", a0, 1);
    chk("cw_val_e6", v0, 0);
    cyc(1);
    chk("cw_val_e7", v0, 1);
    chk("cw_step_e7", {s0, d0}, 2'b11);
    cyc(1);
    chk("cw_step_e8", s0, 0);
    cyc(2);
    enc_a = 1'b0;
    cyc(8);
    repeat (4) detent(1'b0);
    chk("cw_five", v0, 5);
    chk("cw_five_sat", v1, 5);

    // Asynchronous reset mid-operation
    load = 1'b1; load_val = 8'h37;
    cyc(1);
    load = 1'b0;
    chk("load_37", v0, 8'h37);
    enc_a = 1'b1;
    cyc(10);
    chk("pre_rst_val", v0, 8'h38);
    chk("pre_rst_adb", a0, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_val", v0, 0);
    chk("async_rst_adbdir", {a0, d0}, 0);
    cyc(1);
    enc_a = 1'b0;
    rst_n = 1'b1;

    // Counter-clockwise from zero: wrap vs saturate
    enc_b = 1'b1;
    cyc(8);
    chk("ccw_bdb", b0, 1);
    enc_a = 1'b1;
    cyc(6);
    chk("ccw_e6_step", s0, 0);
    cyc(1);
    chk("ccw_wrap", {v0, s0, d0}, {8'hFF, 1'b1, 1'b0});
    chk("ccw_sat", {v1, s1, d1}, {8'h00, 1'b1, 1'b0});
    enc_a = 1'b0;
    cyc(8);

    // Glitch rejection: 3 cycles dropped, 4 accepted
    enc_b = 1'b0;
    cyc(8);
    seen = 1'b0;
    enc_a = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc(1); seen |= a0 | s0; end
    enc_a = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); seen |= a0 | s0; end
    chk("glitch3", seen, 0);
    chk("glitch3_val", v0, 8'hFF);
    seen = 1'b0;
    enc_a = 1'b1;
    for (int i = 0; i < 4; i++) begin cyc(1); seen |= a0; end
    enc_a = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); seen |= a0; end
    chk("glitch4_adb", seen, 1);
    chk("glitch4_wrap", v0, 8'h00);
    chk("glitch4_sat", v1, 8'h01);

    // Load coincident with a rise
    enc_a = 1'b1;
    cyc(6);
    load = 1'b1; load_val = 8'h80;
    cyc(1);
    load = 1'b0;
    chk("load_prio_val", v0, 8'h80);
    chk("load_prio_step", s0, 0);
    enc_a = 1'b0;
    cyc(8);
    detent(1'b0);
    chk("after_load_up", v0, 8'h81);

    // Disabled: everything frozen, load ignored
    ena = 1'b0;
    enc_a = 1'b1; load = 1'b1; load_val = 8'h10;
    cyc(10);
    chk("ena0_val", v0, 8'h81);
    chk("ena0_adb", a0, 0);
    enc_a = 1'b0; load = 1'b0;
    cyc(5);
    enc_a = 1'b1;
    cyc(5);
    chk("ena0_val2", {v0, a0, s0}, {8'h81, 1'b0, 1'b0});
    enc_a = 1'b0;
    cyc(5);
    ena = 1'b1;
    cyc(8);
    chk("ena1_val", v0, 8'h81);

    // Prescaled instance: A raised one cycle after reset release
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    enc_a = 1'b1;
    cyc(7);
    chk("ps_adb_early", a2, 0);
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found) begin
        cyc(1);
        found = a2;
      end
    end
    chk("ps_adb_window", found, 1);
    chk("ps_val_pre", v2, 0);
    cyc(1);
    chk("ps_val_step", {v2, s2, d2}, {8'h01, 1'b1, 1'b1});
    enc_a = 1'b0;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
